lcd_ctrl_gen2: RTL

LCD_CTRL_GEN2 -- requirements
Module: lcd_ctrl_gen2

---
 rtl/lcd_ctrl_pkg.sv | 25 ++
 rtl/lcd_win_alu.sv | 84 ++++++++
 rtl/lcd_ctrl_gen2.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/lcd_ctrl_pkg.sv
// Shared opcode constants and controller state encoding for the LCD
// controller and its window arithmetic unit.
package lcd_ctrl_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    IDLE  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_t;

  localparam logic [3:0] OP_WRITE  = 4'd0;
  localparam logic [3:0] OP_UP     = 4'd1;
  localparam logic [3:0] OP_DOWN   = 4'd2;
  localparam logic [3:0] OP_LEFT   = 4'd3;
  localparam logic [3:0] OP_RIGHT  = 4'd4;
  localparam logic [3:0] OP_AVG    = 4'd5;
  localparam logic [3:0] OP_MIRX   = 4'd6;
  localparam logic [3:0] OP_MIRY   = 4'd7;
  localparam logic [3:0] OP_MAX    = 4'd8;
  localparam logic [3:0] OP_MIN    = 4'd9;
  localparam logic [3:0] OP_ROTCW  = 4'd10;
  localparam logic [3:0] OP_ROTCCW = 4'd11;

endpackage

// File: rtl/lcd_win_alu.sv
// Combinational 2x2 window transform: takes the four window pixels and the
// opcode, returns the four replacement pixels (pass-through for other opcodes).
module lcd_win_alu
  import lcd_ctrl_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [3:0]    op,
  input  logic [DW-1:0] tl,
  input  logic [DW-1:0] tr,
  input  logic [DW-1:0] bl,
  input  logic [DW-1:0] br,
  output logic [DW-1:0] new_tl,
  output logic [DW-1:0] new_tr,
  output logic [DW-1:0] new_bl,
  output logic [DW-1:0] new_br
);

  logic [DW+1:0] sum;
  logic [DW-1:0] hi_top, hi_bot, hi_all;
  logic [DW-1:0] lo_top, lo_bot, lo_all;

  always_comb begin
    // Two extra sum bits so four full-scale pixels never wrap.
    sum    = {2'b00, tl} + {2'b00, tr} + {2'b00, bl} + {2'b00, br};
    hi_top = (tl > tr) ? tl : tr;
    hi_bot = (bl > br) ? bl : br;
    hi_all = (hi_top > hi_bot) ? hi_top : hi_bot;
    lo_top = (tl < tr) ? tl : tr;
    lo_bot = (bl < br) ? bl : br;
    lo_all = (lo_top < lo_bot) ? lo_top : lo_bot;

    new_tl = tl;
    new_tr = tr;
    new_bl = bl;
    new_br = br;
    case (op)
      OP_AVG: begin
        new_tl = sum[DW+1:2];
        new_tr = sum[DW+1:2];
        new_bl = sum[DW+1:2];
        new_br = sum[DW+1:2];
      end
      OP_MIRX: begin
        new_tl = bl;
        new_bl = tl;
        new_tr = br;
        new_br = tr;
      end
      OP_MIRY: begin
        new_tl = tr;
        new_tr = tl;
        new_bl = br;
        new_br = bl;
      end
      OP_MAX: begin
        new_tl = hi_all;
        new_tr = hi_all;
        new_bl = hi_all;
        new_br = hi_all;
      end
      OP_MIN: begin
        new_tl = lo_all;
        new_tr = lo_all;
        new_bl = lo_all;
        new_br = lo_all;
      end
      OP_ROTCW: begin
        new_tl = bl;
        new_tr = tl;
        new_br = tr;
        new_bl = br;
      end
      OP_ROTCCW: begin
        new_tl = tr;
        new_tr = br;
        new_br = bl;
        new_bl = tl;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lcd_ctrl_gen2.sv
// LCD image controller: loads a WxW image from ROM, applies 2x2 window
// commands around a movable operating point, and streams the buffer out.
module lcd_ctrl_gen2
  import lcd_ctrl_pkg::*;
#(
  parameter int DW    = 8,
  parameter int LOG2W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DW-1:0]      IROM_Q,
  input  logic [3:0]         cmd,
  input  logic               cmd_valid,
  output logic               IROM_EN,
  output logic [2*LOG2W-1:0] IROM_A,
  output logic               IRB_RW,
  output logic [DW-1:0]      IRB_D,
  output logic [2*LOG2W-1:0] IRB_A,
  output logic               busy,
  output logic               done
);

  localparam int AW = 2 * LOG2W;
  localparam int N  = 1 << AW;
  localparam logic [LOG2W-1:0] XY_MIN   = LOG2W'(1);
  localparam logic [LOG2W-1:0] XY_MAX   = '1;
  localparam logic [LOG2W-1:0] XY_MID   = {1'b1, {(LOG2W-1){1'b0}}};
  localparam logic [AW:0]      LOAD_END = {1'b1, {AW{1'b0}}};
  localparam logic [AW-1:0]    LAST     = '1;

  state_t state, next_state;

  logic [AW:0]       load_cnt;
  logic [AW-1:0]     load_slot;
  logic [LOG2W-1:0]  px, py, xm1, ym1;
  logic [3:0]        op;
  logic              accept, is_win;
  logic [AW-1:0]     a_tl, a_tr, a_bl, a_br, next_a;
  logic [DW-1:0]     new_tl, new_tr, new_bl, new_br;
  logic [DW-1:0]     pix [N];

  assign accept    = (state == IDLE) && cmd_valid;
  assign is_win    = (op >= OP_AVG) && (op <= OP_ROTCCW);
  // ROM data lags the address by one cycle, so count k captures pixel k-1.
  assign load_slot = load_cnt[AW-1:0] - 1'b1;
  assign next_a    = IRB_A + 1'b1;
  assign xm1       = px - 1'b1;
  assign ym1       = py - 1'b1;
  assign a_tl      = {ym1, xm1};
  assign a_tr      = {ym1, px};
  assign a_bl      = {py, xm1};
  assign a_br      = {py, px};

  assign busy    = (state != IDLE);
  assign IROM_EN = (state != LOAD);
  assign IROM_A  = (state == LOAD && load_cnt != LOAD_END) ? load_cnt[AW-1:0] : '0;

  always_ff @(posedge clk) begin
    if (reset) state <= LOAD;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      LOAD:    if (load_cnt == LOAD_END) next_state = IDLE;
      IDLE:    if (cmd_valid) next_state = (cmd == OP_WRITE) ? WRITE : EXEC;
      EXEC:    next_state = IDLE;
      WRITE:   if (IRB_A == LAST) next_state = IDLE;
      default: next_state = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)                                      load_cnt <= '0;
    else if (state == LOAD && load_cnt != LOAD_END) load_cnt <= load_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == LOAD && load_cnt != '0) begin
        pix[load_slot] <= IROM_Q;
      end else if (state == EXEC && is_win) begin
        pix[a_tl] <= new_tl;
        pix[a_tr] <= new_tr;
        pix[a_bl] <= new_bl;
        pix[a_br] <= new_br;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      px <= XY_MID;
      py <= XY_MID;
      op <= OP_WRITE;
    end else begin
      if (accept) op <= cmd;
      if (state == EXEC) begin
        case (op)
          OP_UP:    if (py != XY_MIN) py <= py - 1'b1;
          OP_DOWN:  if (py != XY_MAX) py <= py + 1'b1;
          OP_LEFT:  if (px != XY_MIN) px <= px - 1'b1;
          OP_RIGHT: if (px != XY_MAX) px <= px + 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Write-out outputs are registered together so address and data line up.
  always_ff @(posedge clk) begin
    if (reset) begin
      IRB_RW <= 1'b1;
      IRB_A  <= '0;
      IRB_D  <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept && cmd == OP_WRITE) begin
        IRB_RW <= 1'b0;
        IRB_A  <= '0;
        IRB_D  <= pix[0];
      end else if (state == WRITE) begin
        if (IRB_A == LAST) begin
          IRB_RW <= 1'b1;
          IRB_A  <= '0;
          IRB_D  <= '0;
          done   <= 1'b1;
        end else begin
          IRB_A <= next_a;
          IRB_D <= pix[next_a];
        end
      end
    end
  end

  lcd_win_alu #(.DW(DW)) u_alu (
    .op     (op),
    .tl     (pix[a_tl]),
    .tr     (pix[a_tr]),
    .bl     (pix[a_bl]),
    .br     (pix[a_br]),
    .new_tl (new_tl),
    .new_tr (new_tr),
    .new_bl (new_bl),
    .new_br (new_br)
  );

endmodule
